decode_v3: RTL

Parametrised decode stage with a micro-op sequencer for multi-element (vector) instructions. It sits between fetch and execute. It reads operands from an internal NREG-entry register file written by writeback. It expands one vector instruction into up to MAXSEQ scalar micro-ops, stalling fetch while it does so. Results are registered into the decode/execute pipeline register.

---
 rtl/decode_pkg.sv | 34 +++
 rtl/decode_v3_if.sv | 59 +++++
 rtl/decode_v3_register_file.sv | 55 +++++
 rtl/decode_v3.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared constants and types for the decode_v3 slice.
// Holds the fixed instruction width, field positions, the vector opcode,
// the sequencer state type and a modular address helper.
package decode_pkg;

   localparam int unsigned IW        = 24;
   localparam int unsigned FIELD_W   = 4;
   localparam int unsigned OPC_LSB   = 21;
   localparam int unsigned OPC_W     = 3;
   localparam int unsigned SE_HI     = 20;
   localparam int unsigned SE_LO     = 0;
   localparam int unsigned RD_LSB    = 16;
   localparam int unsigned RS_LSB    = 12;
   localparam int unsigned RT_LSB    = 8;
   localparam int unsigned CNT_LSB   = 4;
   localparam int unsigned FUNCT_LSB = 1;
   localparam int unsigned FUNCT_W   = 3;
   localparam int unsigned IMM_W     = 12;

   localparam logic [OPC_W-1:0] OP_VEC = 3'b111;

   typedef enum logic {
      IDLE = 1'b0,
      SEQ  = 1'b1
   } seq_state_t;

   // Register index offset by a micro-op number, wrapping at the register count.
   function automatic int unsigned wrap_add(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned modulus);
      return (base + off) % modulus;
   endfunction

endpackage

// File: rtl/decode_v3_if.sv
// decode_v3_if: fetch, writeback and decode/execute signals of the decode stage.
//   master : pipeline side (drives fetch/writeback/control, observes results)
//   slave  : decode_v3 (consumes instruction/writeback, produces execute payload)
interface decode_v3_if
#(
   parameter int unsigned N      = 24,
   parameter int unsigned NREG   = 16,
   parameter int unsigned MAXSEQ = 4
);
   import decode_pkg::*;

   localparam int unsigned AW = $clog2(NREG);
   localparam int unsigned SW = $clog2(MAXSEQ);

   // fetch / control
   logic          ValidD;
   logic [IW-1:0] InstrD;
   logic [N-1:0]  PCPlus8D;
   logic          StallD;
   logic          FlushD;
   logic          FlushE;
   logic          StuckD;
   logic [AW-1:0] RA1H;
   logic [AW-1:0] RA2H;
   // writeback
   logic          RegWriteW;
   logic [AW-1:0] WA3W;
   logic [N-1:0]  ResultW;
   // execute payload
   logic          ValidE;
   logic [2:0]    OpcodeE;
   logic [1:0]    SE;
   logic [2:0]    FunctE;
   logic [N-1:0]  RD1E;
   logic [N-1:0]  RD2E;
   logic [N-1:0]  ExtImmE;
   logic [AW-1:0] WA3E;
   logic [AW-1:0] RA1E;
   logic [AW-1:0] RA2E;
   logic [SW-1:0] SeqIdxE;
   logic          SeqLastE;

   modport master (
      output ValidD, InstrD, PCPlus8D, StallD, FlushD, FlushE,
             RegWriteW, WA3W, ResultW,
      input  StuckD, RA1H, RA2H,
             ValidE, OpcodeE, SE, FunctE, RD1E, RD2E, ExtImmE,
             WA3E, RA1E, RA2E, SeqIdxE, SeqLastE
   );

   modport slave (
      input  ValidD, InstrD, PCPlus8D, StallD, FlushD, FlushE,
             RegWriteW, WA3W, ResultW,
      output StuckD, RA1H, RA2H,
             ValidE, OpcodeE, SE, FunctE, RD1E, RD2E, ExtImmE,
             WA3E, RA1E, RA2E, SeqIdxE, SeqLastE
   );

endinterface

// File: rtl/decode_v3_register_file.sv
// register_file_v3: NREG x N register file, two read ports, one write port.
// Register NREG-1 is not stored: it reads as pc and ignores writes.
// Build option DECODE_BYPASS_EN forwards a same-cycle write to a matching read.
// Ports: clk, rst (async, active-low), we/wa/wd write port,
//        ra1/ra2 read addresses, pc value for NREG-1, rd1/rd2 read data.
module register_file_v3
#(
   parameter int unsigned N    = 24,
   parameter int unsigned NREG = 16
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [$clog2(NREG)-1:0] wa,
   input  logic [N-1:0]            wd,
   input  logic [$clog2(NREG)-1:0] ra1,
   input  logic [$clog2(NREG)-1:0] ra2,
   input  logic [N-1:0]            pc,
   output logic [N-1:0]            rd1,
   output logic [N-1:0]            rd2
);
   localparam int unsigned AW = $clog2(NREG);
   localparam logic [AW-1:0] PC_REG = AW'(NREG - 1);

   logic [N-1:0] mem [NREG];

   // Storage; the PC slot is never written.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(NREG); i++) mem[i] <= '0;
      end else if (we && (wa != PC_REG)) begin
         mem[wa] <= wd;
      end
   end

   // Read port 1
   always_comb begin
      rd1 = mem[ra1];
      if (ra1 == PC_REG) rd1 = pc;
`ifdef DECODE_BYPASS_EN
      else if (we && (wa == ra1)) rd1 = wd;
`endif
   end

   // Read port 2
   always_comb begin
      rd2 = mem[ra2];
      if (ra2 == PC_REG) rd2 = pc;
`ifdef DECODE_BYPASS_EN
      else if (we && (wa == ra2)) rd2 = wd;
`endif
   end

endmodule

// File: rtl/decode_v3.sv
// decode_v3: decode stage with a micro-op sequencer for vector instructions.
// A vector instruction (OP_VEC) expands into cnt scalar micro-ops that walk
// rd/rs/rt forward by the element index; StuckD holds fetch meanwhile.
// Ports: clk, rst (async, active-low), bus (decode_v3_if.slave): fetch/control,
//        writeback, hazard addresses and the registered decode/execute payload.
// Build option DECODE_BYPASS_EN enables writeback-to-read bypass in the register file.
module decode_v3
   import decode_pkg::*;
#(
   parameter int unsigned N      = 24,
   parameter int unsigned NREG   = 16,
   parameter int unsigned MAXSEQ = 4
)
(
   input  logic       clk,
   input  logic       rst,
   decode_v3_if.slave bus
);
   localparam int unsigned AW = $clog2(NREG);
   localparam int unsigned SW = $clog2(MAXSEQ);
   localparam int unsigned CW = SW + 1;

   seq_state_t             state_q, state_d;
   logic [SW-1:0]          idx_q, idx_d;

   logic                   is_vec;
   logic [CW-1:0]          cnt;
   logic [SW-1:0]          k;
   logic                   last_uop;
   logic [AW-1:0]          rd_f, rs_f, rt_f;
   logic [AW-1:0]          wa3, ra1, ra2;
   logic signed [IMM_W-1:0] imm_s;
   logic [N-1:0]           ext_imm;
   logic [N-1:0]           rd1, rd2;

   // Field extraction, current micro-op and its addresses/immediate
   always_comb begin
      is_vec   = bus.InstrD[OPC_LSB +: OPC_W] == OP_VEC;
      cnt      = is_vec ? CW'(bus.InstrD[CNT_LSB +: SW]) + CW'(1) : CW'(1);
      k        = (state_q == SEQ) ? idx_q : '0;
      last_uop = CW'(k) == (cnt - CW'(1));
      rd_f     = AW'(bus.InstrD[RD_LSB +: FIELD_W]);
      rs_f     = AW'(bus.InstrD[RS_LSB +: FIELD_W]);
      rt_f     = AW'(bus.InstrD[RT_LSB +: FIELD_W]);
      wa3      = AW'(wrap_add(32'(rd_f), 32'(k), NREG));
      ra1      = AW'(wrap_add(32'(rs_f), 32'(k), NREG));
      ra2      = AW'(wrap_add(32'(rt_f), 32'(k), NREG));
      imm_s    = bus.InstrD[IMM_W-1:0];
      ext_imm  = is_vec ? N'(k) : N'(imm_s);
   end

   register_file_v3 #(.N(N), .NREG(NREG)) u_rf (
      .clk (clk),
      .rst (rst),
      .we  (bus.RegWriteW),
      .wa  (bus.WA3W),
      .wd  (bus.ResultW),
      .ra1 (ra1),
      .ra2 (ra2),
      .pc  (bus.PCPlus8D),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   // Fetch hold and hazard addresses; StuckD drops on the last micro-op
   assign bus.StuckD = rst & bus.ValidD & ~last_uop;
   assign bus.RA1H   = ra1;
   assign bus.RA2H   = ra2;

   // Sequencer next state; FlushD beats any advance, StallD freezes.
   // The >= exit guards against InstrD shrinking mid-sequence.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (bus.FlushD) begin
         state_d = IDLE;
         idx_d   = '0;
      end else if (!bus.StallD) begin
         unique case (state_q)
            IDLE: begin
               if (bus.ValidD && (cnt > CW'(1))) begin
                  state_d = SEQ;
                  idx_d   = SW'(1);
               end
            end
            SEQ: begin
               if (CW'(idx_q) >= (cnt - CW'(1))) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + SW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
            end
         endcase
      end
   end

   // Sequencer state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Decode/execute register: FlushE bubble beats StallD hold
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.ValidE   <= 1'b0;
         bus.OpcodeE  <= '0;
         bus.SE       <= '0;
         bus.FunctE   <= '0;
         bus.RD1E     <= '0;
         bus.RD2E     <= '0;
         bus.ExtImmE  <= '0;
         bus.WA3E     <= '0;
         bus.RA1E     <= '0;
         bus.RA2E     <= '0;
         bus.SeqIdxE  <= '0;
         bus.SeqLastE <= 1'b0;
      end else if (bus.FlushE) begin
         bus.ValidE   <= 1'b0;
         bus.OpcodeE  <= '0;
         bus.SE       <= '0;
         bus.FunctE   <= '0;
         bus.RD1E     <= '0;
         bus.RD2E     <= '0;
         bus.ExtImmE  <= '0;
         bus.WA3E     <= '0;
         bus.RA1E     <= '0;
         bus.RA2E     <= '0;
         bus.SeqIdxE  <= '0;
         bus.SeqLastE <= 1'b0;
      end else if (!bus.StallD) begin
         bus.ValidE   <= bus.ValidD & ~bus.FlushD;
         bus.OpcodeE  <= bus.InstrD[OPC_LSB +: OPC_W];
         bus.SE       <= {bus.InstrD[SE_HI], bus.InstrD[SE_LO]};
         bus.FunctE   <= bus.InstrD[FUNCT_LSB +: FUNCT_W];
         bus.RD1E     <= rd1;
         bus.RD2E     <= rd2;
         bus.ExtImmE  <= ext_imm;
         bus.WA3E     <= wa3;
         bus.RA1E     <= ra1;
         bus.RA2E     <= ra2;
         bus.SeqIdxE  <= k;
         bus.SeqLastE <= bus.ValidD & ~bus.FlushD & last_uop;
      end
   end

endmodule
